// File: rtl/memory_controller.sv
// memory_controller: arbitrates the load/store buffer and instruction fetch
// onto a byte-wide RAM/IO port, serialising each access into per-byte cycles
// and returning little-endian assembled data with a one-cycle done pulse.
module memory_controller #(
  parameter int unsigned       OP_W       = 1,
  parameter logic [OP_W-1:0]   OP_STORE   = 1'b1,
  parameter logic [1:0]        IO_BASE_HI = 2'b11
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clr_in,
  // load/store buffer
  input  logic            lsb_to_mc_ready,
  input  logic [1:0]      lsb_to_mc_len,
  input  logic [OP_W-1:0] lsb_to_mc_opType,
  input  logic [31:0]     lsb_to_mc_data,
  input  logic [31:0]     lsb_to_mc_addr,
  output logic            mc_to_lsb_ld_done,
  output logic            mc_to_lsb_st_done,
  output logic [31:0]     mc_to_lsb_result,
  // instruction fetch
  input  logic            if_to_mc_ready,
  input  logic [31:0]     if_to_mc_addr,
  output logic            mc_to_if_done,
  output logic [31:0]     mc_to_if_inst,
  // byte-wide RAM / IO
  input  logic [7:0]      mem_din,
  output logic [7:0]      mem_dout,
  output logic [31:0]     mem_a,
  output logic            mem_wr,
  input  logic            io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  len_q, len_d;
  logic        src_if_q, src_if_d;     // 1 = transaction belongs to instruction fetch
  logic [2:0]  cnt_q, cnt_d;           // READ: edges since accept; WRITE: bytes written
  logic [31:0] buf_q, buf_d;           // read bytes assembled so far
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ld_done_q, ld_done_d;
  logic        st_done_q, st_done_d;
  logic        if_done_q, if_done_d;
  logic [31:0] ld_result_q, ld_result_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic [2:0]  n_bytes;
  logic [2:0]  edge_idx;
  logic [31:0] asm_word;
  logic [31:0] wr_addr;
  logic [31:0] data_sh;
  logic        lsb_go;
  logic        if_go;
  logic        acc_stall;
  logic        wr_stall;

  assign n_bytes   = {1'b0, len_q} + 3'd1;
  assign edge_idx  = cnt_q + 3'd1;
  assign wr_addr   = addr_q + 32'(cnt_q);
  assign data_sh   = data_q >> {cnt_q[1:0], 3'b000};
  // A source is not re-accepted in the cycle its done pulse is visible,
  // since requesters drop ready one cycle late.
  assign lsb_go    = lsb_to_mc_ready && !ld_done_q && !st_done_q;
  assign if_go     = if_to_mc_ready && !if_done_q && !clr_in;
  assign acc_stall = (lsb_to_mc_addr[17:16] == IO_BASE_HI) && io_buffer_full;
  assign wr_stall  = (wr_addr[17:16] == IO_BASE_HI) && io_buffer_full;

  // Next-state and datapath decode for the IDLE/READ/WRITE sequencer.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    len_d       = len_q;
    src_if_d    = src_if_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = 1'b0;
    ld_done_d   = 1'b0;
    st_done_d   = 1'b0;
    if_done_d   = 1'b0;
    ld_result_d = ld_result_q;
    if_inst_d   = if_inst_q;
    asm_word    = buf_q;

    unique case (state_q)
      IDLE: begin
        if (lsb_go) begin
          addr_d   = lsb_to_mc_addr;
          data_d   = lsb_to_mc_data;
          len_d    = lsb_to_mc_len;
          src_if_d = 1'b0;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          mem_a_d  = lsb_to_mc_addr;
          if (lsb_to_mc_opType == OP_STORE) begin
            state_d = WRITE;
            if (!acc_stall) begin
              mem_dout_d = lsb_to_mc_data[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = READ;
          end
        end else if (if_go) begin
          addr_d   = if_to_mc_addr;
          len_d    = 2'd3;
          src_if_d = 1'b1;
          cnt_d    = 3'd0;
          buf_d    = 32'd0;
          mem_a_d  = if_to_mc_addr;
          state_d  = READ;
        end
      end

      READ: begin
        if (src_if_q && clr_in) begin
          state_d = IDLE;
        end else begin
          cnt_d = edge_idx;
          if (edge_idx < n_bytes) mem_a_d = addr_q + 32'(edge_idx);
          // RAM data lags the address by one cycle, so lane k arrives two edges after its address.
          if (edge_idx >= 3'd2) asm_word = buf_q | (32'(mem_din) << {edge_idx - 3'd2, 3'b000});
          buf_d = asm_word;
          if (edge_idx == n_bytes + 3'd1) begin
            state_d = IDLE;
            if (src_if_q) begin
              if_done_d = 1'b1;
              if_inst_d = asm_word;
            end else begin
              ld_done_d   = 1'b1;
              ld_result_d = asm_word;
            end
          end
        end
      end

      WRITE: begin
        if (cnt_q == n_bytes) begin
          st_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          mem_a_d = wr_addr;
          if (!wr_stall) begin
            mem_dout_d = data_sh[7:0];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register: synchronous reset, everything frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      len_q       <= '0;
      src_if_q    <= 1'b0;
      cnt_q       <= '0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ld_done_q   <= 1'b0;
      st_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
      ld_result_q <= '0;
      if_inst_q   <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      len_q       <= len_d;
      src_if_q    <= src_if_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ld_done_q   <= ld_done_d;
      st_done_q   <= st_done_d;
      if_done_q   <= if_done_d;
      ld_result_q <= ld_result_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign mem_a             = mem_a_q;
  assign mem_dout          = mem_dout_q;
  assign mem_wr            = mem_wr_q;
  assign mc_to_lsb_ld_done = ld_done_q;
  assign mc_to_lsb_st_done = st_done_q;
  assign mc_to_lsb_result  = ld_result_q;
  assign mc_to_if_done     = if_done_q;
  assign mc_to_if_inst     = if_inst_q;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a byte-wide RAM model that
// answers one cycle after the address and is gated by rdy_in.
module tb_memory_controller;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        lsb_to_mc_ready;
  logic [1:0]  lsb_to_mc_len;
  logic [0:0]  lsb_to_mc_opType;
  logic [31:0] lsb_to_mc_data, lsb_to_mc_addr;
  logic        mc_to_lsb_ld_done, mc_to_lsb_st_done;
  logic [31:0] mc_to_lsb_result;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_inst;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  ram [0:262143];
  logic        pre_we;
  logic [17:0] pre_a;
  logic [7:0]  pre_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  memory_controller dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clr_in            (clr_in),
    .lsb_to_mc_ready   (lsb_to_mc_ready),
    .lsb_to_mc_len     (lsb_to_mc_len),
    .lsb_to_mc_opType  (lsb_to_mc_opType),
    .lsb_to_mc_data    (lsb_to_mc_data),
    .lsb_to_mc_addr    (lsb_to_mc_addr),
    .mc_to_lsb_ld_done (mc_to_lsb_ld_done),
    .mc_to_lsb_st_done (mc_to_lsb_st_done),
    .mc_to_lsb_result  (mc_to_lsb_result),
    .if_to_mc_ready    (if_to_mc_ready),
    .if_to_mc_addr     (if_to_mc_addr),
    .mc_to_if_done     (mc_to_if_done),
    .mc_to_if_inst     (mc_to_if_inst),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  // RAM model: preload port for the bench, otherwise rdy-gated read/write.
  always @(posedge clk_in) begin
    if (pre_we) begin
      ram[pre_a] <= pre_d;
    end else if (rdy_in) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic lsb_req(input logic st, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] data);
    lsb_to_mc_ready  = 1'b1;
    lsb_to_mc_opType = st;
    lsb_to_mc_len    = len;
    lsb_to_mc_addr   = addr;
    lsb_to_mc_data   = data;
  endtask

  initial begin
    logic [31:0] exp_a;
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
    lsb_to_mc_ready = 1'b0; lsb_to_mc_len = 2'd0; lsb_to_mc_opType = 1'b0;
    lsb_to_mc_data = 32'd0; lsb_to_mc_addr = 32'd0;
    if_to_mc_ready = 1'b0; if_to_mc_addr = 32'd0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;

    poke(18'h00100, 8'h13); poke(18'h00101, 8'h00);
    poke(18'h00102, 8'hA0); poke(18'h00103, 8'hE3);
    poke(18'h00202, 8'h5A); poke(18'h00203, 8'h77);
    poke(18'h3FFFF, 8'h11); poke(18'h00000, 8'h22);
    rst_in = 1'b0;

    // reset state
    check("rst_ld_done", 32'(mc_to_lsb_ld_done), 32'd0);
    check("rst_st_done", 32'(mc_to_lsb_st_done), 32'd0);
    check("rst_if_done", 32'(mc_to_if_done), 32'd0);
    check("rst_mem_wr",  32'(mem_wr), 32'd0);
    check("rst_mem_a",   mem_a, 32'd0);
    check("rst_dout",    32'(mem_dout), 32'd0);
    check("rst_result",  mc_to_lsb_result, 32'd0);
    check("rst_inst",    mc_to_if_inst, 32'd0);

    // instruction fetch at 0x100, ready held through the cooldown cycle
    if_to_mc_ready = 1'b1; if_to_mc_addr = 32'h100;
    tick();
    check("if_a0", mem_a, 32'h100);
    check("if_wr0", 32'(mem_wr), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_a = (k <= 3) ? 32'h100 + 32'(k) : 32'h103;
      check($sformatf("if_a%0d", k), mem_a, exp_a);
      check($sformatf("if_wr%0d", k), 32'(mem_wr), 32'd0);
      check($sformatf("if_done%0d", k), 32'(mc_to_if_done), 32'(k == 5));
    end
    check("if_inst", mc_to_if_inst, 32'hE3A00013);
    tick();
    check("if_cool_done", 32'(mc_to_if_done), 32'd0);
    check("if_cool_a", mem_a, 32'h103);
    if_to_mc_ready = 1'b0;

    // half store at 0x200
    lsb_req(1'b1, 2'd1, 32'h200, 32'h1234ABCD);
    tick();
    check("st_wr0", 32'(mem_wr), 32'd1);
    check("st_a0", mem_a, 32'h200);
    check("st_d0", 32'(mem_dout), 32'hCD);
    tick();
    check("st_wr1", 32'(mem_wr), 32'd1);
    check("st_a1", mem_a, 32'h201);
    check("st_d1", 32'(mem_dout), 32'hAB);
    check("st_done1", 32'(mc_to_lsb_st_done), 32'd0);
    tick();
    check("st_wr2", 32'(mem_wr), 32'd0);
    check("st_done2", 32'(mc_to_lsb_st_done), 32'd1);
    tick();
    check("st_cool_done", 32'(mc_to_lsb_st_done), 32'd0);
    check("st_cool_wr", 32'(mem_wr), 32'd0);
    check("st_cool_a", mem_a, 32'h201);
    lsb_to_mc_ready = 1'b0;
    check("ram200", 32'(ram[18'h200]), 32'hCD);
    check("ram201", 32'(ram[18'h201]), 32'hAB);
    check("ram202", 32'(ram[18'h202]), 32'h5A);

    // byte load at 0x201 and its cooldown cycle
    lsb_req(1'b0, 2'd0, 32'h201, 32'd0);
    tick();
    check("lb_a0", mem_a, 32'h201);
    check("lb_wr0", 32'(mem_wr), 32'd0);
    tick();
    check("lb_done1", 32'(mc_to_lsb_ld_done), 32'd0);
    lsb_to_mc_addr = 32'h200;
    tick();
    check("lb_done2", 32'(mc_to_lsb_ld_done), 32'd1);
    check("lb_result", mc_to_lsb_result, 32'h000000AB);
    tick();
    check("lb_cool_done", 32'(mc_to_lsb_ld_done), 32'd0);
    check("lb_cool_a", mem_a, 32'h201);
    lsb_to_mc_ready = 1'b0;

    // LSB word load and IF fetch requested together
    lsb_req(1'b0, 2'd3, 32'h100, 32'd0);
    if_to_mc_ready = 1'b1; if_to_mc_addr = 32'h200;
    tick();
    check("arb_a0", mem_a, 32'h100);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_a = (k <= 3) ? 32'h100 + 32'(k) : 32'h103;
      check($sformatf("arb_a%0d", k), mem_a, exp_a);
      check($sformatf("arb_ld%0d", k), 32'(mc_to_lsb_ld_done), 32'(k == 5));
      check($sformatf("arb_if%0d", k), 32'(mc_to_if_done), 32'd0);
    end
    check("arb_result", mc_to_lsb_result, 32'hE3A00013);
    tick();
    check("arb_if_acc_a", mem_a, 32'h200);
    check("arb_ld_off", 32'(mc_to_lsb_ld_done), 32'd0);
    lsb_to_mc_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("arb_ifdone%0d", k), 32'(mc_to_if_done), 32'(k == 5));
    end
    check("arb_inst", mc_to_if_inst, 32'h775AABCD);
    tick();
    check("arb_if_cool", 32'(mc_to_if_done), 32'd0);
    if_to_mc_ready = 1'b0;

    // clr_in in IDLE blocks IF, then aborts an in-flight fetch
    if_to_mc_ready = 1'b1; if_to_mc_addr = 32'h100; clr_in = 1'b1;
    tick();
    check("clr_idle_a", mem_a, 32'h203);
    clr_in = 1'b0;
    tick();
    check("clr_if_a0", mem_a, 32'h100);
    if_to_mc_ready = 1'b0;
    tick();
    check("clr_if_a1", mem_a, 32'h101);
    clr_in = 1'b1;
    tick();
    check("clr_if_wr", 32'(mem_wr), 32'd0);
    check("clr_if_done", 32'(mc_to_if_done), 32'd0);
    clr_in = 1'b0;
    lsb_req(1'b0, 2'd0, 32'h202, 32'd0);
    tick();
    check("clr_lsb_acc_a", mem_a, 32'h202);
    check("clr_no_if_a", 32'(mc_to_if_done), 32'd0);
    lsb_to_mc_ready = 1'b0;
    tick();
    check("clr_no_if_b", 32'(mc_to_if_done), 32'd0);
    tick();
    check("clr_lb_done", 32'(mc_to_lsb_ld_done), 32'd1);
    check("clr_lb_result", mc_to_lsb_result, 32'h5A);
    check("clr_no_if_c", 32'(mc_to_if_done), 32'd0);
    tick();

    // clr_in does not disturb an in-flight LSB word load
    lsb_req(1'b0, 2'd3, 32'h100, 32'd0);
    tick();
    lsb_to_mc_ready = 1'b0;
    tick();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    tick();
    tick();
    check("clrl_done4", 32'(mc_to_lsb_ld_done), 32'd0);
    tick();
    check("clrl_done5", 32'(mc_to_lsb_ld_done), 32'd1);
    check("clrl_result", mc_to_lsb_result, 32'hE3A00013);
    tick();

    // IO store stalled by a full buffer for three edges
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 2'd0, 32'h30000, 32'h41);
    tick();
    check("io_wr0", 32'(mem_wr), 32'd0);
    lsb_to_mc_ready = 1'b0;
    tick();
    check("io_wr1", 32'(mem_wr), 32'd0);
    tick();
    check("io_wr2", 32'(mem_wr), 32'd0);
    io_buffer_full = 1'b0;
    tick();
    check("io_wr3", 32'(mem_wr), 32'd1);
    check("io_a3", mem_a, 32'h30000);
    check("io_d3", 32'(mem_dout), 32'h41);
    check("io_done3", 32'(mc_to_lsb_st_done), 32'd0);
    tick();
    check("io_done4", 32'(mc_to_lsb_st_done), 32'd1);
    check("io_wr4", 32'(mem_wr), 32'd0);
    tick();
    check("io_done5", 32'(mc_to_lsb_st_done), 32'd0);
    check("io_ram", 32'(ram[18'h30000]), 32'h41);

    // rdy_in low freezes a byte load
    lsb_req(1'b0, 2'd0, 32'h200, 32'd0);
    tick();
    lsb_to_mc_ready = 1'b0;
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rdy_hold%0d", k), 32'(mc_to_lsb_ld_done), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    check("rdy_done1", 32'(mc_to_lsb_ld_done), 32'd0);
    tick();
    check("rdy_done2", 32'(mc_to_lsb_ld_done), 32'd1);
    check("rdy_result", mc_to_lsb_result, 32'hCD);
    tick();

    // half load wrapping from 0xFFFFFFFF to 0x00000000
    lsb_req(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    check("wrap_a0", mem_a, 32'hFFFF_FFFF);
    lsb_to_mc_ready = 1'b0;
    tick();
    check("wrap_a1", mem_a, 32'h0000_0000);
    tick();
    check("wrap_done2", 32'(mc_to_lsb_ld_done), 32'd0);
    tick();
    check("wrap_done3", 32'(mc_to_lsb_ld_done), 32'd1);
    check("wrap_result", mc_to_lsb_result, 32'h0000_2211);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sits between the load/store buffer and instruction fetch (upstream requesters) and the byte-wide unified RAM/IO port (downstream).
- Arbitrates one transaction at a time and serialises 1/2/4-byte loads, stores and 4-byte instruction fetches into per-byte RAM cycles.
- Returns assembled little-endian data with a one-cycle done pulse to the requester.

Parameters:
- OP_W, 1, width of lsb_to_mc_opType.
- OP_STORE, 1, lsb_to_mc_opType value meaning store; any other value means load.
- IO_BASE_HI, 2'b11, addr[17:16] value selecting the IO region (subject to io_buffer_full).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low = hold all state.
- clr_in  in  1  pipeline flush (misprediction).
- lsb_to_mc_ready  in  1  LSB request valid (level).
- lsb_to_mc_len  in  2  bytes minus 1: 0=byte, 1=half, 3=word.
- lsb_to_mc_opType  in  OP_W  load/store select.
- lsb_to_mc_data  in  32  store data; low bytes used.
- lsb_to_mc_addr  in  32  byte address.
- mc_to_lsb_ld_done  out  1  load complete pulse.
- mc_to_lsb_st_done  out  1  store complete pulse.
- mc_to_lsb_result  out  32  load data, zero-extended.
- if_to_mc_ready  in  1  fetch request valid (level).
- if_to_mc_addr  in  32  fetch address.
- mc_to_if_done  out  1  fetch complete pulse.
- mc_to_if_inst  out  32  fetched word.
- mem_din  in  8  RAM read byte, valid one cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  IO write buffer full.

Behaviour:
- Reset: state IDLE. All done pulses, mem_wr, mem_a, mem_dout, results and counters are 0.
- Reset and clr_in are checked only at the clock edge.
- rdy_in low: every register holds. The top level gates the RAM with rdy_in.
- States: IDLE, READ, WRITE.
- Arbitration in IDLE: LSB has priority over IF.
  - The accepting edge latches addr, len (IF len = 3), kind and source, and clears the byte counter.
  - No request is accepted in the cycle right after that source's done pulse. This is a one-cycle cooldown per source, because requesters drop ready one cycle late.
- READ, n = len+1 bytes; accept edge is E0:
  - Ek (k < n) drives mem_a <= addr+k with mem_wr = 0.
  - Edge E(k+2) captures mem_din into byte lane k.
  - At E(n+1) the done pulse is asserted, the result is presented and the state returns to IDLE.
  - Word load: done 5 cycles after accept; byte load: 2 cycles.
  - Unused upper bytes of the result are 0.
- WRITE, n bytes:
  - Ek (k < n) drives mem_a <= addr+k, mem_dout <= data[8k+7:8k], mem_wr <= 1.
  - At En, mem_wr <= 0, st_done <= 1 and the state returns to IDLE.
  - Word store: done 4 cycles after accept.
- IO stall: if addr[17:16] == IO_BASE_HI and io_buffer_full = 1 at a write edge, drive mem_wr <= 0 and retry the same byte next cycle. Loads are not stalled.
- Done pulses last exactly one cycle. Results hold until the next done from the same source.
- Address wrap: addr+k uses 32-bit modulo arithmetic.
- clr_in:
  - An in-flight IF read is aborted at that edge: state IDLE, mem_wr 0, no mc_to_if_done. A pending IF request is not accepted on that edge.
  - An in-flight LSB transaction (already committed) always completes, and its done still pulses.
  - In IDLE, clr_in blocks IF acceptance that edge but not LSB.
- Simultaneous LSB and IF requests in IDLE: LSB wins. IF waits, holding its request.
- At most one transaction is outstanding; requests arriving while busy are ignored until IDLE.

Test Plan:
- RAM[0x100..0x103] = 13 00 A0 E3, IF req addr 0x100 -> mc_to_if_done pulses 5 cycles after accept, inst = 0xE3A00013. mem_a sequence is 0x100..0x103 and mem_wr stays 0.
- LSB store len=1, addr 0x200, data 0x1234ABCD -> mem_wr = 1 for 2 cycles writing CD@0x200 and AB@0x201. st_done pulses at E2; RAM[0x202] is unchanged.
- LSB load len=0 at 0x201 after the previous store -> ld_done at E2, result 0x000000AB. A second request is not accepted in the cooldown cycle.
- LSB and IF both request in the same IDLE cycle -> LSB served first. IF accepted 1 cycle after LSB done; its done follows 5 cycles after its accept.
- IF fetch in flight, clr_in at E2 -> no mc_to_if_done, state IDLE next cycle. Repeat with an LSB word load in flight -> ld_done still at E5 with correct data.
- Store byte 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr held 0 for those 3 cycles, then a single write and st_done the next cycle.
